// File: rtl/nrisc_ula_seq.sv
// Sequencer that drives an external registered ULA: single ULA commands, a
// shift-and-add multiply built from ULA additions, and illegal-code reporting.
module nrisc_ula_seq #(
    parameter int TAM = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [3:0]     op,
    input  logic [TAM-1:0] op_a,
    input  logic [TAM-1:0] op_b,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [TAM-1:0] result,
    output logic [2:0]     flags,
    output logic [TAM-1:0] ula_a,
    output logic [TAM-1:0] ula_b,
    output logic [3:0]     ula_ctrl,
    input  logic [TAM-1:0] ula_out,
    input  logic [2:0]     ula_flags
);

    localparam int CW = $clog2(TAM + 1);
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_ADD = 4'b0000;

    typedef enum logic [3:0] {
        IDLE, ISSUE, CAPT, MTEST, MADD_I, MADD_C, MSHIFT, FIN, ERR
    } state_t;

    state_t         state, state_n;
    logic [3:0]     op_r;
    logic [TAM-1:0] a_r, b_r;
    logic [TAM-1:0] acc, mc, mp;
    logic [CW-1:0]  cnt;
    logic           op_is_ula;

    always_comb begin
        op_is_ula = 1'b0;
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0110, 4'b0111,
            4'b1101, 4'b1110: op_is_ula = 1'b1;
            default:          op_is_ula = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // The ULA bus is only driven in the two issue states and idles at zero otherwise.
    always_comb begin
        state_n  = state;
        busy     = (state != IDLE);
        ula_a    = '0;
        ula_b    = '0;
        ula_ctrl = OP_ADD;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op_is_ula)         state_n = ISSUE;
                    else if (op == OP_MUL) state_n = MTEST;
                    else                   state_n = ERR;
                end
            end
            ISSUE: begin
                ula_a    = a_r;
                ula_b    = b_r;
                ula_ctrl = op_r;
                state_n  = CAPT;
            end
            CAPT:   state_n = IDLE;
            MTEST:  state_n = mp[0] ? MADD_I : MSHIFT;
            MADD_I: begin
                ula_a    = acc;
                ula_b    = mc;
                ula_ctrl = OP_ADD;
                state_n  = MADD_C;
            end
            MADD_C: state_n = MSHIFT;
            MSHIFT: state_n = (cnt == CW'(1)) ? FIN : MTEST;
            FIN:    state_n = IDLE;
            ERR:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            mc     <= '0;
            mp     <= '0;
            cnt    <= '0;
            result <= '0;
            flags  <= '0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r <= op;
                        a_r  <= op_a;
                        b_r  <= op_b;
                        if (op == OP_MUL) begin
                            acc <= '0;
                            mc  <= op_a;
                            mp  <= op_b;
                            cnt <= CW'(TAM);
                        end
                    end
                end
                CAPT: begin
                    result <= ula_out;
                    flags  <= ula_flags;
                    err    <= 1'b0;
                    done   <= 1'b1;
                end
                MADD_C: acc <= ula_out;
                MSHIFT: begin
                    mc  <= mc << 1;
                    mp  <= mp >> 1;
                    cnt <= cnt - CW'(1);
                end
                // Carry from the partial-product additions is deliberately dropped.
                FIN: begin
                    result <= acc;
                    flags  <= {acc[TAM-1], (acc == '0), 1'b0};
                    err    <= 1'b0;
                    done   <= 1'b1;
                end
                ERR: begin
                    result <= '0;
                    flags  <= '0;
                    err    <= 1'b1;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nrisc_ula_seq.sv
// Randomized scoreboard bench for nrisc_ula_seq with a behavioural registered ULA
// stub and a reference model computing results from plain arithmetic.
module tb_nrisc_ula_seq;

    localparam int TAM = 16;

    logic           clk, rst, start;
    logic [3:0]     op;
    logic [TAM-1:0] op_a, op_b;
    logic           busy, done, err;
    logic [TAM-1:0] result;
    logic [2:0]     flags;
    logic [TAM-1:0] ula_a, ula_b;
    logic [3:0]     ula_ctrl;
    logic [TAM-1:0] ula_out;
    logic [2:0]     ula_flags;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  flg;
        logic        er;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    nrisc_ula_seq #(.TAM(TAM)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .err(err), .result(result), .flags(flags),
        .ula_a(ula_a), .ula_b(ula_b), .ula_ctrl(ula_ctrl),
        .ula_out(ula_out), .ula_flags(ula_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behaviour of the external ULA: returns {N,Z,C, result}.
    function automatic logic [18:0] ula_fn(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        cy;
        s  = 17'h0;
        r  = 16'h0;
        cy = 1'b0;
        case (c)
            4'b0000: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; cy = s[16]; end
            4'b0001: begin r = a - b; cy = (a < b); end
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
            4'b0101: begin r = a >> 1; cy = a[0]; end
            4'b0110: begin r = a << 1; cy = a[15]; end
            4'b0111: r = ~a;
            4'b1101: begin r = {a[0], a[15:1]}; cy = a[0]; end
            4'b1110: begin r = {a[14:0], a[15]}; cy = a[15]; end
            default: r = 16'h0;
        endcase
        return {r[15], (r == 16'h0), cy, r};
    endfunction

    always @(posedge clk) {ula_flags, ula_out} <= ula_fn(ula_ctrl, ula_a, ula_b);

    // Expected response and latency (in edges after the sampling edge).
    function automatic exp_t model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [18:0] u;
        logic [31:0] p;
        e.res = 16'h0;
        e.flg = 3'b000;
        e.er  = 1'b0;
        e.due = 0;
        if (o == 4'b1000) begin
            p     = {16'h0, a} * {16'h0, b};
            e.res = p[15:0];
            e.flg = {p[15], (p[15:0] == 16'h0), 1'b0};
            e.due = 2 * TAM + 2 * $countones(b) + 1;
        end else if (o <= 4'd7 || o == 4'd13 || o == 4'd14) begin
            u     = ula_fn(o, a, b);
            e.res = u[15:0];
            e.flg = u[18:16];
            e.due = 2;
        end else begin
            e.er  = 1'b1;
            e.due = 1;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Called #1 after a rising edge; waits for idle, issues one command, returns #1 after the sampling edge.
    task automatic applyStimulus(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        int   guard;
        exp_t e;
        guard = 0;
        while (busy && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy) failNow("busy_timeout");
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        e     = model(o, a, b);
        e.due = e.due + cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while ((busy || sb.size() != 0) && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy || sb.size() != 0) failNow("drain_timeout");
    endtask

    // Monitor: every done pops one expectation; no done may appear unannounced or late.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    failNow("unexpected_done");
                end else begin
                    e = sb.pop_front();
                    checkOutput("done_cycle", cyc, e.due);
                    checkOutput("result", {16'h0, result}, {16'h0, e.res});
                    checkOutput("flags", {29'h0, flags}, {29'h0, e.flg});
                    checkOutput("err", {31'h0, err}, {31'h0, e.er});
                end
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                failNow("missing_done");
                void'(sb.pop_front());
            end
            if (!busy) checkOutput("ula_idle", {12'h0, ula_ctrl, ula_a}, 32'h0);
        end
    end

    initial begin
        int guard;
        logic [3:0] ro;
        rst   = 1'b1;
        start = 1'b0;
        op    = 4'h0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_done", {31'h0, done}, 32'h0);
        checkOutput("rst_err", {31'h0, err}, 32'h0);
        checkOutput("rst_result", {16'h0, result}, 32'h0);
        checkOutput("rst_flags", {29'h0, flags}, 32'h0);
        checkOutput("rst_ula", {ula_ctrl, 12'h0, ula_b}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(4'b0010, 16'hAAAA, 16'h5555);
        checkOutput("issue_ctrl", {28'h0, ula_ctrl}, 32'h2);
        checkOutput("issue_a", {16'h0, ula_a}, 32'hAAAA);

        applyStimulus(4'b1000, 16'd3, 16'd5);
        @(posedge clk); #1;
        checkOutput("madd_b", {16'h0, ula_b}, 32'h3);
        applyStimulus(4'b1000, 16'h0100, 16'h0100);
        applyStimulus(4'b1000, 16'h1234, 16'h0000);
        applyStimulus(4'b1010, 16'h1111, 16'h2222);
        checkOutput("err_no_issue", {ula_ctrl, 12'h0, ula_a}, 32'h0);
        waitIdle();

        applyStimulus(4'b1000, 16'h00F0, 16'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; op = 4'b0000; op_a = 16'h0001; op_b = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_ignore", {31'h0, busy}, 32'h1);
        guard = 0;
        while (!done && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!done) failNow("mul_done_wait");
        applyStimulus(4'b0001, 16'h0001, 16'h0002);
        checkOutput("busy_b2b", {31'h0, busy}, 32'h1);
        waitIdle();

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) ro = 4'b1000;
            applyStimulus(ro, 16'($urandom), 16'($urandom));
        end
        waitIdle();

        applyStimulus(4'b0000, 16'h1234, 16'h1111);
        waitIdle();
        applyStimulus(4'b1000, 16'h00FF, 16'h0F0F);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", {31'h0, busy}, 32'h0);
        checkOutput("abort_done", {31'h0, done}, 32'h0);
        checkOutput("abort_result", {16'h0, result}, 32'h0);
        checkOutput("abort_flags", {29'h0, flags}, 32'h0);
        sb.delete();
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(4'b0000, 16'hAAAA, 16'h5555);
        waitIdle();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nrisc_ula_seq.md
NRISC_ULA_SEQ -- requirements
Module: nrisc_ula_seq

Interface
REQ-001 Parameter: TAM, default 16, data width of operands, result and ULA buses.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  command request, sampled on rising clk when busy=0.
REQ-005 op  input  4  command code: ULA codes 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SHR, 0110 SHL, 0111 NOT, 1101 RTR, 1110 RTL; 1000 MUL; all other codes illegal.
REQ-006 op_a / op_b  input  TAM each  command operands.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  one-cycle registered pulse; result/flags/err valid while high and held until next done.
REQ-009 err  output  1  set with done when the command code was illegal.
REQ-010 result  output  TAM  command result.
REQ-011 flags  output  3  {N,Z,C}: bit2 negative, bit1 zero, bit0 carry.
REQ-012 ula_a / ula_b  output  TAM each  operands to the ULA.
REQ-013 ula_ctrl  output  4  operation code to the ULA.
REQ-014 ula_out  input  TAM, ula_flags  input  3  ULA registered result and flags, valid the cycle after an issue cycle.

Function
REQ-015 States SHALL be IDLE, ISSUE, CAPT, MTEST, MADD_I, MADD_C, MSHIFT, FIN, ERR.
REQ-016 IDLE: start=1 captures op, op_a, op_b; ULA code -> ISSUE; 1000 -> MTEST with acc=0, mc=op_a, mp=op_b, cnt=16; illegal -> ERR; start=0 stays IDLE.
REQ-017 start while busy=1 SHALL be ignored; start in the done cycle SHALL be accepted (busy is already 0).
REQ-018 ISSUE: ula_a=op_a, ula_b=op_b, ula_ctrl=op for exactly one cycle -> CAPT.
REQ-019 CAPT: result<=ula_out, flags<=ula_flags unchanged, err<=0, done<=1 -> IDLE.
REQ-020 Single-op latency: start sampled at edge N -> done high after edge N+2.
REQ-021 MTEST: mp[0]=1 -> MADD_I, else -> MSHIFT.
REQ-022 MADD_I: ula_a=acc, ula_b=mc, ula_ctrl=0000 for one cycle -> MADD_C; MADD_C: acc<=ula_out -> MSHIFT.
REQ-023 MSHIFT: mc<=mc<<1, mp<=mp>>1 (zero fill), cnt<=cnt-1; cnt=1 -> FIN, else -> MTEST.
REQ-024 MUL SHALL always run 16 iterations (TAM iterations in general), no early exit when mp=0.
REQ-025 FIN: result<=acc (low TAM bits of unsigned product), flags<={acc[TAM-1], acc==0, 0}, err<=0, done<=1 -> IDLE; ULA carry from ADDs discarded.
REQ-026 MUL latency: done high after edge N + 2*TAM + 2*popcount(op_b) + 1.
REQ-027 ERR: result<=0, flags<=000, err<=1, done<=1 -> IDLE; no ULA issue; done after edge N+1.
REQ-028 Outside ISSUE/MADD_I: ula_a=0, ula_b=0, ula_ctrl=0000.
REQ-029 done SHALL be low in every cycle except the one following a CAPT, FIN or ERR edge.

Reset
REQ-030 rst=1 SHALL immediately, independent of clk, force state IDLE, busy=0, done=0, err=0, result=0, flags=000, acc/mc/mp/cnt=0, ula_a/ula_b/ula_ctrl=0.
REQ-031 rst asserted mid-command SHALL abort it with no done; first start after rst release behaves as from power-up.

Verification
REQ-032 op=0010, a=0xAAAA, b=0x5555 -> ula_ctrl=0010 during ISSUE, done after edge N+2, result=0x0000, flags=010, err=0.
REQ-033 op=1000, a=3, b=5 -> exactly two ULA ADD issues, result=0x000F, flags=000, done after edge N+37.
REQ-034 op=1000, a=0x0100, b=0x0100 -> result=0x0000, flags=010, done after edge N+35; b=0 -> result 0, flags 010, done after N+33.
REQ-035 start pulsed mid-MUL -> ignored, busy stays 1; start held high in done cycle -> second command accepted, busy high next cycle.
REQ-036 op=1010 -> done after edge N+1, err=1, result=0, flags=000, ula_ctrl stays 0000.
REQ-037 rst pulsed between clock edges during MUL -> busy, done, result, flags go 0 immediately; subsequent op=0000, a=0xAAAA, b=0x5555 -> result=0xFFFF, flags=100.
